// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Shared types and helpers for the serdes serializer.
//   ser_state_e : serializer FSM state (IDLE, SEND)
//   count_w()   : width of the word counter for a given word count; at least
//                 1 bit so that N_SAMPLES == 1 still yields a legal vector.
// -----------------------------------------------------------------------------
package serdes_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  function automatic int count_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serdes_serializer_control.sv
// -----------------------------------------------------------------------------
// serializer_control
// FSM and word counter for the serializer. The datapath (vector register and
// word mux) lives in the parent; this block only decides when to load and
// which word to present.
//
// Handshake: a transfer happens on a rising clk edge where val && rdy.
// send_val depends only on registered state. recv_rdy depends only on state,
// except with SERDES_SERIALIZER_PIPELINE_EN defined, where on the last word it
// follows send_rdy so a new vector can load in the same cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   recv_val / recv_rdy upstream handshake
//   send_val / send_rdy downstream handshake
//   load_en             capture recv_msg into the vector register this edge
//   sel                 index of the word currently presented
//   state               current FSM state (observation only)
//
// Optional macro: SERDES_SERIALIZER_PIPELINE_EN (back-to-back vectors).
// -----------------------------------------------------------------------------
module serializer_control
  import serdes_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int CW        = count_w(N_SAMPLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          recv_val,
  output logic          recv_rdy,
  output logic          send_val,
  input  logic          send_rdy,
  output logic          load_en,
  output logic [CW-1:0] sel,
  output ser_state_e    state
);

  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);

  ser_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          last;
  logic          rdy_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Explicit compare so a non-power-of-2 count stops at N_SAMPLES-1.
  assign last = (count_q == LAST);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rdy_raw  = 1'b0;
    send_val = 1'b0;
    load_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy_raw = 1'b1;
        if (recv_val && reset) begin
          load_en = 1'b1;
          count_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        send_val = 1'b1;
`ifdef SERDES_SERIALIZER_PIPELINE_EN
        if (last) rdy_raw = send_rdy;
`endif
        if (send_rdy) begin
          if (last) begin
            count_d = '0;
            state_d = IDLE;
            // rdy_raw is only ever high here with the pipeline macro.
            if (rdy_raw && recv_val) begin
              load_en = 1'b1;
              state_d = SEND;
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Never advertise readiness while reset is held.
  assign recv_rdy = rdy_raw & reset;
  assign sel      = count_q;
  assign state    = state_q;

endmodule

// File: rtl/serdes_serializer.sv
// -----------------------------------------------------------------------------
// serdes_serializer
// Parallel-to-serial converter: accepts one N_SAMPLES x BIT_WIDTH vector and
// emits it as N_SAMPLES words, word 0 (LSBs of recv_msg) first.
//
// Ports:
//   clk       clock, all state updates on posedge
//   reset     asynchronous active-low reset
//   recv_val  / recv_rdy / recv_msg [N_SAMPLES*BIT_WIDTH]  vector input
//   send_val  / send_rdy / send_msg [BIT_WIDTH]            word output
//
// N_SAMPLES == 1 is a combinational pass-through (clk/reset unused).
// send_msg outside send_val shows the indexed word of the held vector; sinks
// must ignore it.
//
// Optional macro: SERDES_SERIALIZER_PIPELINE_EN lets a new vector load on the
// cycle the last word leaves, giving N_SAMPLES cycles per vector.
// -----------------------------------------------------------------------------
module serdes_serializer
  import serdes_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg,
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic [BIT_WIDTH-1:0]           send_msg
);

  if (N_SAMPLES == 1) begin : g_pass
    assign recv_rdy = send_rdy;
    assign send_val = recv_val;
    assign send_msg = recv_msg;
  end else begin : g_ser
    localparam int CW = count_w(N_SAMPLES);

    logic                           load_en;
    logic [CW-1:0]                  sel;
    ser_state_e                     state;
    logic [N_SAMPLES*BIT_WIDTH-1:0] data_q;

    serializer_control #(
      .N_SAMPLES (N_SAMPLES),
      .CW        (CW)
    ) u_ctrl (
      .clk      (clk),
      .reset    (reset),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy),
      .send_val (send_val),
      .send_rdy (send_rdy),
      .load_en  (load_en),
      .sel      (sel),
      .state    (state)
    );

    // recv_msg is captured only on a recv transfer; later changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)       data_q <= '0;
      else if (load_en) data_q <= recv_msg;
    end

    // Cleared data and count make send_msg read 0 while reset is held.
    assign send_msg = data_q[int'(sel)*BIT_WIDTH +: BIT_WIDTH];
  end

endmodule

// File: tb/tb_serdes_serializer.sv
// -----------------------------------------------------------------------------
// tb_serdes_serializer
// Directed bench for serdes_serializer: an N=8/BW=32 instance for the main
// flow, an N=5/BW=8 instance for the non-power-of-2 count and an N=1/BW=8
// instance for the pass-through case. Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_serdes_serializer;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // N=8, BW=32
  logic         recv_val = 1'b0, recv_rdy, send_val, send_rdy = 1'b0;
  logic [255:0] recv_msg = '0;
  logic [31:0]  send_msg;
  // N=5, BW=8
  logic         recv_val_5 = 1'b0, recv_rdy_5, send_val_5, send_rdy_5 = 1'b1;
  logic [39:0]  recv_msg_5 = '0;
  logic [7:0]   send_msg_5;
  // N=1, BW=8
  logic         recv_val_1 = 1'b0, recv_rdy_1, send_val_1, send_rdy_1 = 1'b0;
  logic [7:0]   recv_msg_1 = '0;
  logic [7:0]   send_msg_1;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serdes_serializer #(.N_SAMPLES(8), .BIT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg)
  );

  serdes_serializer #(.N_SAMPLES(5), .BIT_WIDTH(8)) dut5 (
    .clk(clk), .reset(reset),
    .recv_val(recv_val_5), .recv_rdy(recv_rdy_5), .recv_msg(recv_msg_5),
    .send_val(send_val_5), .send_rdy(send_rdy_5), .send_msg(send_msg_5)
  );

  serdes_serializer #(.N_SAMPLES(1), .BIT_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset),
    .recv_val(recv_val_1), .recv_rdy(recv_rdy_1), .recv_msg(recv_msg_1),
    .send_val(send_val_1), .send_rdy(send_rdy_1), .send_msg(send_msg_1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [255:0] make_vec(input logic [31:0] base);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = base + 32'(i);
    return v;
  endfunction

  // Sends one vector into the N=8 instance and checks every word out.
  // bp=0: send_rdy held high; bp=1: send_rdy pattern 1,0,0,1 repeating.
  task automatic run_vector(input logic [255:0] vec, input int bp);
    int          cycles;
    logic        was_held;
    logic [31:0] held;
    for (int i = 0; i < 8; i++) exp_q.push_back(vec[i*32 +: 32]);
    @(negedge clk);
    recv_val = 1'b1;
    recv_msg = vec;
    send_rdy = (bp == 0);
    #1;
    check("accept_rdy", recv_rdy, 1);
    check("accept_val", send_val, 0);
    @(negedge clk);
    recv_val = 1'b0;
    recv_msg = {8{$urandom()}};   // must not affect words in flight
    cycles   = 0;
    was_held = 1'b0;
    held     = '0;
    while (exp_q.size() > 0 && cycles < 200) begin
      send_rdy = (bp == 0) ? 1'b1 : ((cycles % 4 == 0) || (cycles % 4 == 3));
      #1;
      check("busy_val", send_val, 1);
`ifdef SERDES_SERIALIZER_PIPELINE_EN
      if (exp_q.size() > 1) check("busy_rdy", recv_rdy, 0);
`else
      check("busy_rdy", recv_rdy, 0);
`endif
      if (was_held) check("held_word", send_msg, held);
      if (send_rdy) check("word", send_msg, exp_q.pop_front());
      was_held = !send_rdy;
      held     = send_msg;
      cycles++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) check("timeout", exp_q.size(), 0);
    exp_q.delete();
    #1;
    check("done_rdy", recv_rdy, 1);
    check("done_val", send_val, 0);
    if (bp == 0) check("cycles", cycles, 8);
  endtask

  initial begin
    // Reset held: outputs quiet.
    #2;
    check("rst_rdy", recv_rdy, 0);
    check("rst_val", send_val, 0);
    check("rst_msg", send_msg, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_rdy", recv_rdy, 1);
    check("idle_val", send_val, 0);
    check("idle_msg", send_msg, 0);

    // Single vector at full rate, then with backpressure.
    run_vector(make_vec(32'h10), 0);
    run_vector(make_vec(32'h50), 1);

    // Async reset after word 3 has been sent.
    @(negedge clk);
    recv_val = 1'b1;
    recv_msg = make_vec(32'h20);
    send_rdy = 1'b1;
    @(negedge clk);
    recv_val = 1'b0;
    #1;
    check("mid_word0", send_msg, 32'h20);
    repeat (4) @(posedge clk);   // words 0..3 consumed
    #1;
    check("mid_word4", send_msg, 32'h24);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_val", send_val, 0);
    check("mid_rst_rdy", recv_rdy, 0);
    check("mid_rst_msg", send_msg, 0);
    @(negedge clk);
    reset = 1'b1;
    run_vector(make_vec(32'hA0), 0);

    // N=5: exactly five words, then idle.
    begin
      int cnt;
      cnt = 0;
      @(negedge clk);
      recv_val_5 = 1'b1;
      recv_msg_5 = 40'h3534333231;
      #1;
      check("n5_accept_rdy", recv_rdy_5, 1);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        recv_val_5 = 1'b0;
        #1;
        if (send_val_5) begin
          check("n5_word", send_msg_5, 64'(8'h31 + cnt));
          cnt++;
        end
      end
      check("n5_count", cnt, 5);
      check("n5_idle_rdy", recv_rdy_5, 1);
    end

    // N=1: combinational pass-through.
    recv_val_1 = 1'b1; send_rdy_1 = 1'b0; recv_msg_1 = 8'h5A;
    #1;
    check("n1_val", send_val_1, 1);
    check("n1_rdy", recv_rdy_1, 0);
    check("n1_msg", send_msg_1, 8'h5A);
    recv_val_1 = 1'b0; send_rdy_1 = 1'b1; recv_msg_1 = 8'hC3;
    #1;
    check("n1_val2", send_val_1, 0);
    check("n1_rdy2", recv_rdy_1, 1);
    check("n1_msg2", send_msg_1, 8'hC3);

`ifdef SERDES_SERIALIZER_PIPELINE_EN
    // Three back-to-back vectors: 24 words in 24 consecutive cycles.
    begin
      int loaded, words, first, last_k;
      loaded = 0; words = 0; first = -1; last_k = -1;
      @(negedge clk);
      recv_val = 1'b1;
      send_rdy = 1'b1;
      recv_msg = make_vec(32'h100);
      for (int k = 0; k < 40; k++) begin
        #1;
        if (send_val) begin
          if (first < 0) first = k;
          last_k = k;
          check("pipe_word", send_msg, exp_q.pop_front());
          words++;
        end
        if (recv_val && recv_rdy) begin
          for (int i = 0; i < 8; i++) exp_q.push_back(recv_msg[i*32 +: 32]);
          loaded++;
        end
        @(negedge clk);
        if (loaded < 3) recv_msg = make_vec(32'h100 + 32'(loaded) * 32'h10);
        else recv_val = 1'b0;
      end
      exp_q.delete();
      check("pipe_words", words, 24);
      check("pipe_span", last_k - first + 1, 24);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
